// File: rtl/postalu.sv
// postalu: 6502 ALU output stage - adder hold register, flags, SB/ADL drive.
// Define POSTALU_DECIMAL_EN to include the one-cycle BCD correction FSM.
module postalu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_vout,
  input  logic       alu_hc,
  input  logic       ldadd,
  input  logic       decen,
  input  logic       sub,
  input  logic       addsb06,
  input  logic       addsb7,
  input  logic       addadl,
  output logic [7:0] sbOut,
  output logic [7:0] sbDrv,
  output logic [7:0] adlOut,
  output logic       adlDrv,
  output logic       cOut,
  output logic       vOut,
  output logic       zOut,
  output logic       nOut,
  output logic       ready
);

  logic [7:0] hold;
  logic [7:0] hold_nxt;
  logic       c_nxt;
  logic       v_nxt;
  logic       z_nxt;
  logic       n_nxt;

`ifdef POSTALU_DECIMAL_EN
  typedef enum logic {
    IDLE    = 1'b0,
    CORRECT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       sub_q;
  logic       hc_q;
  logic       cout_q;
  logic       lat;
  logic       lo;
  logic       hi;
  logic [7:0] adj;

  // FSM state and the adder context needed by the correction cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sub_q  <= 1'b0;
      hc_q   <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (lat) begin
        sub_q  <= sub;
        hc_q   <= alu_hc;
        cout_q <= alu_cout;
      end
    end
  end

  // next hold/flags: binary load in IDLE, BCD adjust in CORRECT
  always_comb begin
    hold_nxt  = hold;
    c_nxt     = cOut;
    v_nxt     = vOut;
    z_nxt     = zOut;
    n_nxt     = nOut;
    state_nxt = state;
    lat       = 1'b0;
    adj       = 8'h00;
    lo        = hc_q | (hold[3:0] > 4'd9);
    hi        = cout_q | (hold > 8'h99);
    unique case (state)
      IDLE: begin
        if (ldadd) begin
          hold_nxt = alu_res;
          c_nxt    = alu_cout;
          v_nxt    = alu_vout;
          z_nxt    = (alu_res == 8'h00);
          n_nxt    = alu_res[7];
          if (decen) begin
            lat       = 1'b1;
            state_nxt = CORRECT;
          end
        end
      end
      CORRECT: begin
        if (sub_q) begin
          adj      = {1'b0, ~cout_q, ~cout_q, 1'b0,
                      1'b0, ~hc_q, ~hc_q, 1'b0};
          hold_nxt = hold - adj;
          c_nxt    = cout_q;
        end else begin
          adj      = {1'b0, hi, hi, 1'b0,
                      1'b0, lo, lo, 1'b0};
          hold_nxt = hold + adj;
          c_nxt    = cout_q | hi;
        end
        state_nxt = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
`else
  logic unused_dec;
  assign unused_dec = ^{decen, sub, alu_hc};

  // next hold/flags: every load is binary
  always_comb begin
    hold_nxt = hold;
    c_nxt    = cOut;
    v_nxt    = vOut;
    z_nxt    = zOut;
    n_nxt    = nOut;
    if (ldadd) begin
      hold_nxt = alu_res;
      c_nxt    = alu_cout;
      v_nxt    = alu_vout;
      z_nxt    = (alu_res == 8'h00);
      n_nxt    = alu_res[7];
    end
  end

  assign ready = 1'b1;
`endif

  // adder hold register and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= 8'h00;
      cOut <= 1'b0;
      vOut <= 1'b0;
      zOut <= 1'b0;
      nOut <= 1'b0;
    end else begin
      hold <= hold_nxt;
      cOut <= c_nxt;
      vOut <= v_nxt;
      zOut <= z_nxt;
      nOut <= n_nxt;
    end
  end

  assign sbDrv  = {addsb7, {7{addsb06}}};
  assign sbOut  = hold & sbDrv;
  assign adlDrv = addadl;
  assign adlOut = addadl ? hold : 8'h00;

endmodule

// File: tb/tb_postalu.sv
// tb_postalu: directed and random checks of postalu.
// Decimal expectations follow POSTALU_DECIMAL_EN.
module tb_postalu;

`ifdef POSTALU_DECIMAL_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       alu_vout;
  logic       alu_hc;
  logic       ldadd;
  logic       decen;
  logic       sub;
  logic       addsb06;
  logic       addsb7;
  logic       addadl;
  logic [7:0] sbOut;
  logic [7:0] sbDrv;
  logic [7:0] adlOut;
  logic       adlDrv;
  logic       cOut;
  logic       vOut;
  logic       zOut;
  logic       nOut;
  logic       ready;

  int tests = 0;
  int fails = 0;

  postalu dut (
    .clk      (clk),
    .reset    (reset),
    .alu_res  (alu_res),
    .alu_cout (alu_cout),
    .alu_vout (alu_vout),
    .alu_hc   (alu_hc),
    .ldadd    (ldadd),
    .decen    (decen),
    .sub      (sub),
    .addsb06  (addsb06),
    .addsb7   (addsb7),
    .addadl   (addadl),
    .sbOut    (sbOut),
    .sbDrv    (sbDrv),
    .adlOut   (adlOut),
    .adlDrv   (adlDrv),
    .cOut     (cOut),
    .vOut     (vOut),
    .zOut     (zOut),
    .nOut     (nOut),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] r, input logic co,
                      input logic vo, input logic h,
                      input logic d, input logic s);
    alu_res  = r;
    alu_cout = co;
    alu_vout = vo;
    alu_hc   = h;
    decen    = d;
    sub      = s;
    ldadd    = 1'b1;
    tick();
    ldadd    = 1'b0;
  endtask

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  logic [7:0] a, b, opb, res, exp_h, sb_m;
  logic       ci, is_sub, dm, co, hc, vo, e06, e7, ea;
  int         sum, r;

  initial begin
    reset = 1'b1;
    alu_res = 8'h00; alu_cout = 1'b0; alu_vout = 1'b0;
    alu_hc = 1'b0; ldadd = 1'b0; decen = 1'b0; sub = 1'b0;
    addsb06 = 1'b0; addsb7 = 1'b0; addadl = 1'b0;
    tick();
    tick();
    chk("rst_sbOut", sbOut, 8'h00);
    chk("rst_sbDrv", sbDrv, 8'h00);
    chk("rst_adlOut", adlOut, 8'h00);
    chk("rst_adlDrv", 8'(adlDrv), 8'h00);
    chk("rst_flags", {4'h0, cOut, vOut, zOut, nOut}, 8'h00);
    chk("rst_ready", 8'(ready), 8'h01);
    reset = 1'b0;

    load(8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bin_flags", {4'h0, cOut, vOut, zOut, nOut}, 8'h0D);
    chk("bin_ready", 8'(ready), 8'h01);
    addsb06 = 1'b1;
    #1;
    chk("sb06_out", sbOut, 8'h00);
    chk("sb06_drv", sbDrv, 8'h7F);
    addsb7 = 1'b1;
    #1;
    chk("sb7_out", sbOut, 8'h80);
    chk("sb7_drv", sbDrv, 8'hFF);
    addadl = 1'b1;
    #1;
    chk("adl_out", adlOut, 8'h80);
    chk("adl_drv", 8'(adlDrv), 8'h01);

    load(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_flags", {4'h0, cOut, vOut, zOut, nOut}, 8'h02);

    load(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("d15p27_raw", adlOut, 8'h3C);
    chk("d15p27_busy", 8'(ready), DEC ? 8'h00 : 8'h01);
    tick();
    chk("d15p27_res", adlOut, DEC ? 8'h42 : 8'h3C);
    chk("d15p27_c", 8'(cOut), 8'h00);
    chk("d15p27_rdy", 8'(ready), 8'h01);

    load(8'h9E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("d58p46_res", adlOut, DEC ? 8'h04 : 8'h9E);
    chk("d58p46_flags", {4'h0, cOut, vOut, zOut, nOut},
        DEC ? 8'h09 : 8'h01);

    load(8'h2D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    load(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("d42m15_res", adlOut, DEC ? 8'h27 : 8'h11);
    chk("d42m15_c", 8'(cOut), DEC ? 8'h01 : 8'h00);
    chk("d42m15_rdy", 8'(ready), 8'h01);

    load(8'h9E, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_hold", adlOut, 8'h00);
    chk("midrst_flags", {4'h0, cOut, vOut, zOut, nOut}, 8'h00);
    chk("midrst_rdy", 8'(ready), 8'h01);
    tick();
    chk("midrst_idle", adlOut, 8'h00);

    for (int i = 0; i < 40; i++) begin
      a      = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      b      = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ci     = 1'($urandom);
      is_sub = 1'($urandom);
      dm     = 1'($urandom);
      vo     = 1'($urandom);
      e06    = 1'($urandom);
      e7     = 1'($urandom);
      ea     = 1'($urandom);
      opb    = is_sub ? ~b : b;
      sum    = int'(a) + int'(opb) + int'(ci);
      res    = 8'(sum);
      co     = (sum > 255);
      hc     = (int'(a[3:0]) + int'(opb[3:0]) + int'(ci)) > 15;
      addsb06 = e06;
      addsb7  = e7;
      addadl  = ea;
      load(res, co, vo, hc, dm, is_sub);
      sb_m = {e7, e06, e06, e06, e06, e06, e06, e06};
      chk("rnd_adl", adlOut, ea ? res : 8'h00);
      chk("rnd_sb", sbOut, res & sb_m);
      chk("rnd_flags", {4'h0, cOut, vOut, zOut, nOut},
          {4'h0, co, vo, (res == 8'h00), res[7]});
      chk("rnd_ready", 8'(ready), (DEC && dm) ? 8'h00 : 8'h01);
`ifdef POSTALU_DECIMAL_EN
      if (dm) begin
        tick();
        if (is_sub) begin
          r = bcd2int(a) - bcd2int(b) - (ci ? 0 : 1);
          co = (r >= 0);
          if (r < 0) r += 100;
        end else begin
          r = bcd2int(a) + bcd2int(b) + (ci ? 1 : 0);
          co = (r >= 100);
          r = r % 100;
        end
        exp_h = int2bcd(r);
        chk("rnd_bcd", adlOut, ea ? exp_h : 8'h00);
        chk("rnd_bcd_sb", sbOut, exp_h & sb_m);
        chk("rnd_bcd_flags", {4'h0, cOut, vOut, zOut, nOut},
            {4'h0, co, vo, (res == 8'h00), res[7]});
        chk("rnd_bcd_rdy", 8'(ready), 8'h01);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/postalu.md
# postalu

Output stage of the 6502 ALU: captures the combinational adder result and flags into the adder hold register, applies optional BCD correction over one extra cycle, and drives the held value onto the SB and ADL internal buses under control of the decode/timing logic. It is the counterpart of the pre-ALU operand registers, which feed operands into the ALU.

## Interface
- No parameters.
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- alu_res  input  8  combinational ALU result
- alu_cout  input  1  ALU carry out of bit 7
- alu_vout  input  1  ALU signed overflow
- alu_hc  input  1  ALU carry out of bit 3 (half carry)
- ldadd  input  1  latch ALU result and flags this edge
- decen  input  1  decimal mode for this operation, sampled with ldadd
- sub  input  1  operation is subtraction, sampled with ldadd
- addsb06  input  1  drive hold[6:0] onto SB
- addsb7  input  1  drive hold[7] onto SB
- addadl  input  1  drive hold[7:0] onto ADL
- sbOut  output  8  SB bus value; undriven bits are 0
- sbDrv  output  8  per-bit SB drive enables
- adlOut  output  8  ADL bus value; 0 when undriven
- adlDrv  output  1  ADL drive enable
- cOut, vOut, zOut, nOut  output  1 each  registered flags
- ready  output  1  high when no correction is pending

## Operation
- Registers: hold[7:0], flags C/V/Z/N, latched sub/hc/cout, state {IDLE, CORRECT}.
- IDLE + ldadd: hold <= alu_res; C <= alu_cout; V <= alu_vout; Z <= (alu_res==0); N <= alu_res[7]. If decen=1, latch sub, alu_hc, alu_cout; next state CORRECT. Otherwise remain IDLE.
- CORRECT (one cycle, unconditional): hold <= corrected value; C updated as below; V, Z, N keep their binary-result values; next state IDLE.
- Add correction: lo = hc | (hold[3:0] > 9); hi = cout | (hold > 0x99); hold <= hold + (lo ? 0x06 : 0) + (hi ? 0x60 : 0), mod 256; C <= cout | hi.
- Sub correction: hold <= hold - (hc ? 0 : 0x06) - (cout ? 0 : 0x60), mod 256; C <= cout.
- ldadd asserted in CORRECT is ignored; the sequencer must wait for ready.
- Bus drive is purely combinational from hold and enables: sbDrv = {addsb7, {7{addsb06}}}; sbOut = hold & sbDrv; adlDrv = addadl; adlOut = addadl ? hold : 0. During CORRECT, buses show the uncorrected value.
- Reset, including mid-CORRECT: hold=0x00, C=V=Z=N=0, state IDLE.

## Timing
- Reset values: sbOut=0x00, sbDrv=0x00, adlOut=0x00, adlDrv=0, cOut=vOut=zOut=nOut=0, ready=1.
- Binary path: ldadd at edge N, result and flags visible after edge N; ready stays 1.
- Decimal path: ldadd at edge N puts the binary result in hold and drives ready=0 after edge N. The corrected hold and C appear after edge N+1, with ready=1.
- ready = (state == IDLE), combinational from state.
- Drive enables take effect in the same cycle; there is no registered output stage.

## Configuration
- POSTALU_DECIMAL_EN defined: decimal FSM and correction logic are present as described.
- Not defined: decen is ignored; every ldadd takes the binary path; no CORRECT state; ready is tied to 1.

## Test plan
- Reset: hold all enables low and assert reset -> all outputs 0, ready=1; zOut=0 even though hold=0x00.
- Binary load: ldadd with alu_res=0x80, cout=1, vout=1, decen=0 -> next cycle C=1, V=1, N=1, Z=0. Drive addsb06=1, addsb7=0 -> sbOut=0x00, sbDrv=0x7F; then addsb7=1 -> sbOut=0x80; addadl=1 -> adlOut=0x80.
- Decimal add 15+27: alu_res=0x3C, hc=0, cout=0, decen=1, sub=0 -> ready=0 for one cycle with hold=0x3C; then hold=0x42, C=0, ready=1.
- Decimal add 58+46: alu_res=0x9E, hc=0, cout=0 -> after correction hold=0x04, C=1, N=1 (binary), Z=0.
- Decimal sub 42-15: alu_res=0x2D, hc=0, cout=1, sub=1 -> hold=0x27, C=1. Assert ldadd with 0x11 during CORRECT -> ignored, hold=0x27.
- Reset mid-CORRECT: assert reset during the CORRECT cycle -> next cycle hold=0x00, ready=1, flags 0. With POSTALU_DECIMAL_EN undefined, the 15+27 stimulus gives hold=0x3C and ready remains 1.
